sonar_ping_scheduler: RTL and testbench

Top-level sequencer for the sonar measurement loop. It runs one ping at a time: transmit burst, ringdown blanking, listen window, one-cycle report, then cooldown. It steps the transmit/receive steering index through NUM_BEAMS directions and captures the first-echo time of flight for each ping. It drives the transmit beamformer enable, the beamformer/ToF clear pulse, and the per-beam results that feed range conversion and the display.

---
 rtl/sonar_ping_scheduler.sv | 144 ++++++++++++++
 tb/tb_sonar_ping_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sonar_ping_scheduler.sv
`timescale 1ns/1ps
// Sonar ping sequencer: BURST -> BLANK -> LISTEN -> REPORT -> COOLDOWN,
// stepping the steering index once per ping and reporting first-echo ToF.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | not pinging; waits for enable_in
//   BURST    | transmit burst, tx_en_out high; clear pulse on first cycle
//   BLANK    | transducer ringdown, echo_in ignored
//   LISTEN   | echo window, exits early on the first echo
//   REPORT   | one-cycle result strobe
//   COOLDOWN | quiet gap; steering index advances on its last cycle
module sonar_ping_scheduler #(
  parameter int BURST_CYCLES    = 40000,
  parameter int BLANK_CYCLES    = 50000,
  parameter int LISTEN_CYCLES   = 3000000,
  parameter int COOLDOWN_CYCLES = 2000000,
  parameter int NUM_BEAMS       = 8,
  parameter int TOF_WIDTH       = 24
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         enable_in,
  input  logic                         echo_in,
  output logic                         tx_en_out,
  output logic                         bf_clear_out,
  output logic                         listen_out,
  output logic [$clog2(NUM_BEAMS)-1:0] steer_idx_out,
  output logic                         busy_out,
  output logic                         result_valid_out,
  output logic [$clog2(NUM_BEAMS)-1:0] result_beam_out,
  output logic [TOF_WIDTH-1:0]         result_tof_out,
  output logic                         result_hit_out
);

  localparam int SW      = $clog2(NUM_BEAMS);
  localparam int MAX_AB  = (BURST_CYCLES > BLANK_CYCLES) ? BURST_CYCLES : BLANK_CYCLES;
  localparam int MAX_CD  = (LISTEN_CYCLES > COOLDOWN_CYCLES) ? LISTEN_CYCLES : COOLDOWN_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int PH_W    = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BURST, S_BLANK, S_LISTEN, S_REPORT, S_COOLDOWN
  } state_t;

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [TOF_WIDTH-1:0]  tof_q, tof_d;
  logic [SW-1:0]         steer_q, steer_d;

  logic                  tx_en_d, bf_clear_d, listen_d, busy_d, valid_d, hit_d;
  logic [SW-1:0]         beam_d;
  logic [TOF_WIDTH-1:0]  res_tof_d;

  logic burst_last, blank_last, listen_last, cool_last;

  assign burst_last  = (phase_q == PH_W'(BURST_CYCLES - 1));
  assign blank_last  = (phase_q == PH_W'(BLANK_CYCLES - 1));
  assign listen_last = (phase_q == PH_W'(LISTEN_CYCLES - 1));
  assign cool_last   = (phase_q == PH_W'(COOLDOWN_CYCLES - 1));

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; enable_in only matters in IDLE and at the cooldown exit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (enable_in)                state_d = S_BURST;
      S_BURST:    if (burst_last)               state_d = S_BLANK;
      S_BLANK:    if (blank_last)               state_d = S_LISTEN;
      S_LISTEN:   if (echo_in || listen_last)   state_d = S_REPORT;
      S_REPORT:                                 state_d = S_COOLDOWN;
      S_COOLDOWN: if (cool_last)                state_d = enable_in ? S_BURST : S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are decoded from the next state so they register cleanly
  always_comb begin
    tx_en_d    = (state_d == S_BURST);
    bf_clear_d = (state_d == S_BURST) && (state_q != S_BURST);
    listen_d   = (state_d == S_LISTEN);
    busy_d     = (state_d != S_IDLE);
    valid_d    = (state_d == S_REPORT);

    beam_d     = result_beam_out;
    hit_d      = result_hit_out;
    res_tof_d  = result_tof_out;
    if ((state_q == S_LISTEN) && (state_d == S_REPORT)) begin
      beam_d    = steer_q;
      hit_d     = echo_in;
      res_tof_d = echo_in ? tof_q : '0;
    end

    if ((state_d != state_q) || (state_q == S_IDLE)) phase_d = '0;
    else                                             phase_d = phase_q + 1'b1;

    tof_d = tof_q;
    if ((state_d == S_BURST) && (state_q != S_BURST))
      tof_d = '0;
    else if ((state_q inside {S_BURST, S_BLANK, S_LISTEN}) && (tof_q != '1))
      tof_d = tof_q + 1'b1;

    steer_d = steer_q;
    if ((state_q == S_COOLDOWN) && cool_last)
      steer_d = (steer_q == SW'(NUM_BEAMS - 1)) ? '0 : steer_q + 1'b1;
  end

  // Registered outputs, phase/ToF counters and steering index
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q          <= '0;
      tof_q            <= '0;
      steer_q          <= '0;
      tx_en_out        <= 1'b0;
      bf_clear_out     <= 1'b0;
      listen_out       <= 1'b0;
      busy_out         <= 1'b0;
      result_valid_out <= 1'b0;
      result_beam_out  <= '0;
      result_tof_out   <= '0;
      result_hit_out   <= 1'b0;
    end else begin
      phase_q          <= phase_d;
      tof_q            <= tof_d;
      steer_q          <= steer_d;
      tx_en_out        <= tx_en_d;
      bf_clear_out     <= bf_clear_d;
      listen_out       <= listen_d;
      busy_out         <= busy_d;
      result_valid_out <= valid_d;
      result_beam_out  <= beam_d;
      result_tof_out   <= res_tof_d;
      result_hit_out   <= hit_d;
    end
  end

  assign steer_idx_out = steer_q;

endmodule

// File: tb/tb_sonar_ping_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for sonar_ping_scheduler with short timing parameters.
module tb_sonar_ping_scheduler;
  localparam int BURST = 4, BLANK = 3, LISTEN = 10, COOL = 5, NB = 4, TW = 24;
  localparam int SW = 2;

  logic clk_in = 1'b0;
  logic rst_in, enable_in, echo_in;
  logic tx_en_out, bf_clear_out, listen_out, busy_out, result_valid_out, result_hit_out;
  logic [SW-1:0] steer_idx_out, result_beam_out;
  logic [TW-1:0] result_tof_out;
  logic [33:0]   all_out;

  assign all_out = {tx_en_out, bf_clear_out, listen_out, steer_idx_out, busy_out,
                    result_valid_out, result_beam_out, result_tof_out, result_hit_out};

  always #5 clk_in = ~clk_in;

  sonar_ping_scheduler #(
    .BURST_CYCLES(BURST), .BLANK_CYCLES(BLANK), .LISTEN_CYCLES(LISTEN),
    .COOLDOWN_CYCLES(COOL), .NUM_BEAMS(NB), .TOF_WIDTH(TW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .echo_in(echo_in),
    .tx_en_out(tx_en_out), .bf_clear_out(bf_clear_out), .listen_out(listen_out),
    .steer_idx_out(steer_idx_out), .busy_out(busy_out),
    .result_valid_out(result_valid_out), .result_beam_out(result_beam_out),
    .result_tof_out(result_tof_out), .result_hit_out(result_hit_out)
  );

  typedef struct { int cyc; int beam; int tof; bit hit; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_run = 0;
  int bf_run = 0;
  bit busy_watch = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result strobe and watches pulse widths
  always @(negedge clk_in) begin
    if (result_valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_cycle", cyc, mon_e.cyc);
        chk("result_beam", result_beam_out, mon_e.beam);
        chk("result_tof", result_tof_out, mon_e.tof);
        chk("result_hit", result_hit_out, mon_e.hit);
      end
    end
    if (tx_en_out === 1'b1) tx_run++;
    else if (tx_run != 0) begin
      chk("tx_en_length", tx_run, BURST);
      tx_run = 0;
    end
    if (bf_clear_out === 1'b1) bf_run++;
    else if (bf_run != 0) begin
      chk("bf_clear_width", bf_run, 1);
      bf_run = 0;
    end
    if (busy_watch) chk("busy_held", busy_out, 1);
  end

  task automatic wait_burst(input int exp_start, output int c0);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bf_clear_out === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    chk("burst_seen", found, 1);
    c0 = cyc;
    if (found && exp_start >= 0) chk("burst_start_cycle", cyc, exp_start);
  endtask

  // k = listen cycle of the echo (-1 = none); pre_echo drives echo during burst/blank
  task automatic run_ping(input int exp_start, input int k, input bit pre_echo,
                          input int beam, input int drop_rel, output int c0);
    int last;
    exp_t e;
    wait_burst(exp_start, c0);
    if (k >= 0) e = '{c0 + 8 + k, beam, 7 + k, 1'b1};
    else        e = '{c0 + 17, beam, 0, 1'b0};
    sb_q.push_back(e);
    last = (k >= 0) ? 7 + k : 16;
    for (int r = 0; r <= last; r++) begin
      echo_in = ((k >= 0) && (r == 7 + k)) || (pre_echo && (r < 7));
      if (r == drop_rel) enable_in = 1'b0;
      @(negedge clk_in);
    end
    echo_in = 1'b0;
  endtask

  initial begin
    int c0, t, nxt;
    rst_in = 1'b1; enable_in = 1'b1; echo_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_outputs", all_out, 0);
    rst_in = 1'b0; echo_in = 1'b0; t = cyc;

    run_ping(t + 1, 2, 1'b0, 0, -1, c0);          // tof 9
    run_ping(c0 + 16, -1, 1'b0, 1, -1, c0);        // miss, report at +17
    run_ping(c0 + 23, 9, 1'b1, 2, -1, c0);         // early echoes ignored, tof 16
    nxt = c0 + 23;

    busy_watch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_ping(nxt, 0, 1'b0, (3 + i) % NB, -1, c0); // tof 7, beams 3,0,1,2,3
      nxt = c0 + 14;
    end
    busy_watch = 1'b0;

    run_ping(nxt, 1, 1'b0, 0, 5, c0);              // enable dropped in BLANK
    repeat (5) @(negedge clk_in);
    chk("busy_last_cooldown", busy_out, 1);
    chk("steer_before_exit", steer_idx_out, 0);
    @(negedge clk_in);
    chk("idle_busy", busy_out, 0);
    chk("idle_steer", steer_idx_out, 1);
    chk("idle_tx", tx_en_out, 0);
    chk("held_tof", result_tof_out, 8);
    chk("held_hit", result_hit_out, 1);
    chk("held_beam", result_beam_out, 0);
    repeat (10) @(negedge clk_in);
    chk("idle_stays", busy_out, 0);

    enable_in = 1'b1; t = cyc;
    wait_burst(t + 1, c0);
    repeat (10) @(negedge clk_in);
    chk("in_listen", listen_out, 1);
    chk("listen_steer", steer_idx_out, 1);
    rst_in = 1'b1;
    #1;
    chk("async_reset_outputs", all_out, 0);
    enable_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (30) @(negedge clk_in);
    chk("post_reset_outputs", all_out, 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
